// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: load alignment, register-file write port, load stall/fault, instret
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_kill,
  input  logic [4:0]  mem_waddr,
  input  logic        mem_we,
  input  logic [31:0] mem_result,
  input  logic [4:0]  mem_access,
  input  logic        mem_unsigned,
  input  logic        flush,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_address,
  output logic        wb_we,
  output logic        wb_stall,
  output logic        wb_load_fault,
  output logic [31:0] wb_fault_addr,
  output logic [63:0] instret
);

  localparam int CW = $clog2(LOAD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    ld_waddr;
  logic [1:0]    ld_size;
  logic          ld_unsigned;
  logic [31:0]   ld_addr;

  logic          accept;
  logic          is_load;
  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   load_data;
  logic          unused_access_bit;

  // mem_access[2] carries no meaning for this stage
  assign unused_access_bit = mem_access[2];

  assign accept   = (state == RUN) && mem_valid && !mem_kill && !flush;
  assign is_load  = mem_access[4] && !mem_access[3];
  // Stall comes from state alone so it never forms a combinational path from inputs
  assign wb_stall = (state == WAIT);

  // Select the addressed byte/half lane and extend it to 32 bits; size 11 falls to word
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    load_data = dmem_rdata;
    case (ld_addr[1:0])
      2'b00:   byte_lane = dmem_rdata[7:0];
      2'b01:   byte_lane = dmem_rdata[15:8];
      2'b10:   byte_lane = dmem_rdata[23:16];
      default: byte_lane = dmem_rdata[31:24];
    endcase
    half_lane = ld_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_size)
      2'b00:   load_data = {{24{byte_lane[7] & ~ld_unsigned}}, byte_lane};
      2'b01:   load_data = {{16{half_lane[15] & ~ld_unsigned}}, half_lane};
      default: load_data = dmem_rdata;
    endcase
  end

  // RUN/WAIT state machine with registered write port, fault pulse and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      cnt           <= '0;
      ld_waddr      <= 5'd0;
      ld_size       <= 2'b00;
      ld_unsigned   <= 1'b0;
      ld_addr       <= 32'd0;
      wb_data       <= 32'd0;
      wb_address    <= 5'd0;
      wb_we         <= 1'b0;
      wb_load_fault <= 1'b0;
      wb_fault_addr <= 32'd0;
      instret       <= 64'd0;
    end else begin
      wb_we         <= 1'b0;
      wb_load_fault <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            if (is_load) begin
              ld_waddr    <= mem_waddr;
              ld_size     <= mem_access[1:0];
              ld_unsigned <= mem_unsigned;
              ld_addr     <= mem_result;
              cnt         <= '0;
              state       <= WAIT;
            end else begin
              wb_we      <= mem_we && (mem_waddr != 5'd0);
              wb_address <= mem_waddr;
              wb_data    <= mem_result;
              instret    <= instret + 64'd1;
            end
          end
        end
        WAIT: begin
          if (flush) begin
            state <= RUN;
          end else if (dmem_err) begin
            state         <= RUN;
            wb_load_fault <= 1'b1;
            wb_fault_addr <= ld_addr;
          end else if (dmem_ack) begin
            state      <= RUN;
            wb_data    <= load_data;
            wb_we      <= (ld_waddr != 5'd0);
            wb_address <= ld_waddr;
            instret    <= instret + 64'd1;
          end else if (cnt == CNT_LAST) begin
            state         <= RUN;
            wb_load_fault <= 1'b1;
            wb_fault_addr <= ld_addr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard testbench for wb_stage
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_kill;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic [31:0] mem_result;
  logic [4:0]  mem_access;
  logic        mem_unsigned;
  logic        flush;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        dmem_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_address;
  logic        wb_we;
  logic        wb_stall;
  logic        wb_load_fault;
  logic [31:0] wb_fault_addr;
  logic [63:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_instret = 64'd0;
  logic [36:0] exp_wr[$];
  logic [31:0] exp_flt[$];

  wb_stage #(.LOAD_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_kill(mem_kill), .mem_waddr(mem_waddr), .mem_we(mem_we),
    .mem_result(mem_result), .mem_access(mem_access), .mem_unsigned(mem_unsigned),
    .flush(flush), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
    .wb_data(wb_data), .wb_address(wb_address), .wb_we(wb_we), .wb_stall(wb_stall),
    .wb_load_fault(wb_load_fault), .wb_fault_addr(wb_fault_addr), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every register write or fault pulse must match the head of its expectation queue
  always @(negedge clk) begin
    logic [36:0] e;
    logic [31:0] fa;
    if (wb_we === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x%0d=%h, required no write", wb_address, wb_data);
      end else begin
        e = exp_wr.pop_front();
        if ({wb_address, wb_data} !== e) begin
          errors++;
          $display("FAIL write: got x%0d=%h, required x%0d=%h", wb_address, wb_data, e[36:32], e[31:0]);
        end
      end
    end
    if (wb_load_fault === 1'b1) begin
      checks++;
      if (exp_flt.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fault: got fault addr %h, required no fault", wb_fault_addr);
      end else begin
        fa = exp_flt.pop_front();
        if (wb_fault_addr !== fa) begin
          errors++;
          $display("FAIL fault_addr: got %h, required %h", wb_fault_addr, fa);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_kill = 0; mem_we = 0; mem_waddr = 0; mem_result = 0;
    mem_access = 0; mem_unsigned = 0; flush = 0; dmem_ack = 0; dmem_err = 0;
  endtask

  task automatic chk_instret();
    @(negedge clk);
    chk("instret", instret, exp_instret);
  endtask

  task automatic alu(input logic [4:0] waddr, input logic [31:0] result, input logic we);
    mem_valid = 1; mem_we = we; mem_waddr = waddr; mem_result = result; mem_access = 5'b00000;
    if (we && waddr != 0) exp_wr.push_back({waddr, result});
    exp_instret++;
    step();
    idle_inputs();
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] access, input logic uns,
                      input logic [4:0] waddr);
    mem_valid = 1; mem_we = 1; mem_waddr = waddr; mem_result = addr;
    mem_access = access; mem_unsigned = uns;
    step();
    idle_inputs();
  endtask

  task automatic hold_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("stall_in_wait", {63'd0, wb_stall}, 64'd1);
      step();
    end
  endtask

  task automatic ack_load(input logic [31:0] rdata, input logic [4:0] waddr, input logic [31:0] exp_data);
    dmem_rdata = rdata; dmem_ack = 1;
    if (waddr != 0) exp_wr.push_back({waddr, exp_data});
    exp_instret++;
    @(negedge clk);
    chk("stall_ack_cycle", {63'd0, wb_stall}, 64'd1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("stall_release", {63'd0, wb_stall}, 64'd0);
  endtask

  task automatic err_load(input logic [31:0] addr, input logic with_ack);
    dmem_err = 1; dmem_ack = with_ack; dmem_rdata = 32'h1111_2222;
    exp_flt.push_back(addr);
    step();
    idle_inputs();
    @(negedge clk);
    chk("stall_after_err", {63'd0, wb_stall}, 64'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
    chk("rst_wb_address", {59'd0, wb_address}, 64'd0);
    chk("rst_wb_we", {63'd0, wb_we}, 64'd0);
    chk("rst_wb_stall", {63'd0, wb_stall}, 64'd0);
    chk("rst_wb_load_fault", {63'd0, wb_load_fault}, 64'd0);
    chk("rst_wb_fault_addr", {32'd0, wb_fault_addr}, 64'd0);
    chk("rst_instret", instret, 64'd0);
  endtask

  initial begin
    idle_inputs();
    dmem_rdata = 0;
    rst = 1;
    step();
    step();
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 0;

    // ALU retires, x0 target, store, back-to-back
    alu(5'd5, 32'h1234_5678, 1);
    chk_instret();
    alu(5'd0, 32'hCAFE_0000, 1);
    mem_valid = 1; mem_we = 0; mem_waddr = 5'd6; mem_result = 32'h0000_0100; mem_access = 5'b11010;
    exp_instret++;
    step();
    idle_inputs();
    @(negedge clk);
    chk("store_no_stall", {63'd0, wb_stall}, 64'd0);
    chk_instret();
    alu(5'd1, 32'h0000_000A, 1);
    alu(5'd31, 32'hFFFF_FFFF, 1);
    chk_instret();

    // Bubble, kill, flush in RUN and stray acks: nothing retires
    mem_we = 1; mem_waddr = 5'd3; mem_result = 32'h3; step();
    mem_valid = 1; mem_kill = 1; step();
    mem_kill = 0; flush = 1; step();
    idle_inputs();
    dmem_ack = 1; dmem_rdata = 32'h7777_7777; step();
    idle_inputs();
    chk_instret();

    // LB signed/unsigned, ack three cycles after accept
    load(32'h0000_1003, 5'b10000, 0, 5'd7);
    hold_wait(2);
    ack_load(32'h8000_0000, 5'd7, 32'hFFFF_FF80);
    load(32'h0000_1003, 5'b10000, 1, 5'd8);
    hold_wait(2);
    ack_load(32'h8000_0000, 5'd8, 32'h0000_0080);
    // LH upper half at minimum latency, LHU lower half, LW to x0
    load(32'h0000_2002, 5'b10001, 0, 5'd9);
    ack_load(32'hABCD_0000, 5'd9, 32'hFFFF_ABCD);
    load(32'h0000_2000, 5'b10001, 1, 5'd10);
    hold_wait(1);
    ack_load(32'h1234_8765, 5'd10, 32'h0000_8765);
    load(32'h0000_4000, 5'b10010, 0, 5'd0);
    ack_load(32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    load(32'h0000_4001, 5'b10000, 0, 5'd11);
    ack_load(32'h0000_9A00, 5'd11, 32'hFFFF_FF9A);
    chk_instret();

    // Bus error, fault address holds across a later retire
    load(32'h0000_3000, 5'b10010, 0, 5'd12);
    hold_wait(1);
    err_load(32'h0000_3000, 0);
    chk_instret();
    alu(5'd2, 32'h0000_0022, 1);
    @(negedge clk);
    chk("fault_addr_held", {32'd0, wb_fault_addr}, 64'h0000_3000);

    // Timeout on the 16th WAIT cycle
    load(32'h0000_5004, 5'b10010, 0, 5'd13);
    exp_flt.push_back(32'h0000_5004);
    hold_wait(16);
    @(negedge clk);
    chk("stall_after_timeout", {63'd0, wb_stall}, 64'd0);
    chk_instret();

    // Error and ack together: error wins
    load(32'h0000_6000, 5'b10001, 0, 5'd14);
    hold_wait(3);
    err_load(32'h0000_6000, 1);
    chk_instret();

    // Flush together with ack: abandon, no write, no fault
    load(32'h0000_7000, 5'b10010, 0, 5'd15);
    hold_wait(1);
    flush = 1; dmem_ack = 1; dmem_rdata = 32'h5555_AAAA;
    step();
    idle_inputs();
    @(negedge clk);
    chk("stall_after_flush", {63'd0, wb_stall}, 64'd0);
    chk_instret();

    // Reset in the middle of WAIT, with an ack on the same edge
    load(32'h0000_8000, 5'b10010, 0, 5'd16);
    hold_wait(2);
    rst = 1; dmem_ack = 1; dmem_rdata = 32'h0BAD_0BAD;
    exp_instret = 64'd0;
    step();
    idle_inputs();
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 0;
    alu(5'd4, 32'h0000_0044, 1);
    chk_instret();

    step();
    step();
    chk("write_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("fault_queue_drained", 64'(exp_flt.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
